// File: rtl/signal_bank_if.sv
// Request/status bundle for signal_bank: per-channel requests, modes and
// shared hold value in, per-channel state, edge pulses and busy flags out.
interface signal_bank_if #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 16
);
    logic [CHANNELS-1:0]   i_posedge;
    logic [CHANNELS-1:0]   i_negedge;
    logic [CHANNELS-1:0]   i_edge;
    logic [2*CHANNELS-1:0] i_mode;
    logic [CNT_W-1:0]      i_hold;
    logic [CHANNELS-1:0]   o_out;
    logic [CHANNELS-1:0]   o_rise;
    logic [CHANNELS-1:0]   o_fall;
    logic [CHANNELS-1:0]   o_busy;

    // Requester side: drives requests and configuration, observes state.
    modport master (
        output i_posedge, i_negedge, i_edge, i_mode, i_hold,
        input  o_out, o_rise, o_fall, o_busy
    );

    // Bank side.
    modport slave (
        input  i_posedge, i_negedge, i_edge, i_mode, i_hold,
        output o_out, o_rise, o_fall, o_busy
    );
endinterface

// File: rtl/signal_bank.sv
// Bank of independent set/clear/toggle flops, each with a runtime mode
// (level, retriggerable one-shot, periodic blink) and registered rise/fall
// pulses. The shared hold value is the only coupling between channels.
module signal_bank #(
    parameter int                  CHANNELS  = 8,
    parameter int                  CNT_W     = 16,
    parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    signal_bank_if.slave  io_sb
);
    localparam logic [1:0]       MODE_ONESHOT = 2'b01;
    localparam logic [1:0]       MODE_BLINK   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    // A hold of zero would never expire, so it is promoted to one cycle.
    logic [CNT_W-1:0] w_hold;
    assign w_hold = (io_sb.i_hold == '0) ? CNT_ONE : io_sb.i_hold;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic             r_out;
            logic             r_rise;
            logic             r_fall;
            logic             r_busy;
            logic [1:0]       r_mode;
            logic [CNT_W-1:0] r_cnt;

            logic             w_out_next;
            logic             w_busy_next;
            logic [CNT_W-1:0] w_cnt_next;
            logic [1:0]       w_mode_in;
            logic             w_set;
            logic             w_clr;
            logic             w_tog;

            // Fixed priority: only the strongest active request is seen.
            assign w_mode_in = io_sb.i_mode[2*gi +: 2];
            assign w_set     = io_sb.i_posedge[gi];
            assign w_clr     = !io_sb.i_posedge[gi] && io_sb.i_negedge[gi];
            assign w_tog     = !io_sb.i_posedge[gi] && !io_sb.i_negedge[gi]
                               && io_sb.i_edge[gi];

            // Next channel state from mode, requests and timer.
            always_comb begin
                w_out_next  = r_out;
                w_busy_next = r_busy;
                w_cnt_next  = r_cnt;
                if (w_mode_in != r_mode) begin
                    // Mode switch cycle: stop the timer, hold the output,
                    // and drop any request arriving alongside.
                    w_busy_next = 1'b0;
                    w_cnt_next  = '0;
                end else begin
                    case (r_mode)
                        MODE_ONESHOT: begin
                            if (w_set || (w_tog && !r_out)) begin
                                w_out_next  = 1'b1;
                                w_busy_next = 1'b1;
                                w_cnt_next  = w_hold;
                            end else if (w_clr || (w_tog && r_out)) begin
                                w_out_next  = 1'b0;
                                w_busy_next = 1'b0;
                                w_cnt_next  = '0;
                            end else if (r_busy) begin
                                if (r_cnt == CNT_ONE) begin
                                    w_out_next  = 1'b0;
                                    w_busy_next = 1'b0;
                                    w_cnt_next  = '0;
                                end else begin
                                    w_cnt_next = r_cnt - CNT_ONE;
                                end
                            end
                        end
                        MODE_BLINK: begin
                            if (w_set || (w_tog && !r_busy)) begin
                                w_out_next  = 1'b1;
                                w_busy_next = 1'b1;
                                w_cnt_next  = w_hold;
                            end else if (w_clr || (w_tog && r_busy)) begin
                                w_out_next  = 1'b0;
                                w_busy_next = 1'b0;
                                w_cnt_next  = '0;
                            end else if (r_busy) begin
                                if (r_cnt == CNT_ONE) begin
                                    w_out_next = !r_out;
                                    w_cnt_next = w_hold;
                                end else begin
                                    w_cnt_next = r_cnt - CNT_ONE;
                                end
                            end
                        end
                        default: begin
                            // Level mode (and the reserved encoding).
                            w_busy_next = 1'b0;
                            w_cnt_next  = '0;
                            if (w_set) begin
                                w_out_next = 1'b1;
                            end else if (w_clr) begin
                                w_out_next = 1'b0;
                            end else if (w_tog) begin
                                w_out_next = !r_out;
                            end
                        end
                    endcase
                end
            end

            // Channel state and edge pulses, reset straight to idle.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    r_out  <= RESET_VAL[gi];
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    r_busy <= 1'b0;
                    r_mode <= 2'b00;
                    r_cnt  <= '0;
                end else begin
                    r_out  <= w_out_next;
                    r_rise <= !r_out && w_out_next;
                    r_fall <= r_out && !w_out_next;
                    r_busy <= w_busy_next;
                    r_mode <= w_mode_in;
                    r_cnt  <= w_cnt_next;
                end
            end

            assign io_sb.o_out[gi]  = r_out;
            assign io_sb.o_rise[gi] = r_rise;
            assign io_sb.o_fall[gi] = r_fall;
            assign io_sb.o_busy[gi] = r_busy;
        end
    endgenerate
endmodule

// File: tb/tb_signal_bank.sv
// Directed bench for signal_bank: reset value, level priority, one-shot
// length and retrigger, zero hold, blink waveform, mode switch and
// asynchronous reset.
module tb_signal_bank;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    signal_bank_if #(.CHANNELS(8), .CNT_W(16)) bus ();

    signal_bank #(
        .CHANNELS (8),
        .CNT_W    (16),
        .RESET_VAL(8'hA5)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .io_sb(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [7:0] p, input logic [7:0] n, input logic [7:0] e);
        bus.i_posedge = p;
        bus.i_negedge = n;
        bus.i_edge    = e;
    endtask

    // Bit patterns for the blink run, index j = observation after set edge.
    logic [12:0] bl_out  = 13'h11C7;
    logic [12:0] bl_rise = 13'h1040;
    logic [12:0] bl_fall = 13'h0208;

    initial begin
        rst_n = 1'b0;
        req(8'h00, 8'h00, 8'h00);
        bus.i_mode = 16'h0000;
        bus.i_hold = 16'd0;
        cyc();
        cyc();
        check("reset_out", bus.o_out, 8'hA5);
        check("reset_flags", {bus.o_rise, bus.o_fall, bus.o_busy}, 24'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("idle_out", bus.o_out, 8'hA5);
            check("idle_flags", {bus.o_rise, bus.o_fall, bus.o_busy}, 24'h0);
        end

        // LEVEL ch0: clear first so the combined request produces a rise.
        req(8'h00, 8'h01, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("lvl_clr_out", bus.o_out, 8'hA4);
        check("lvl_clr_fall", bus.o_fall, 8'h01);
        req(8'h01, 8'h01, 8'h01); cyc(); req(8'h00, 8'h00, 8'h00);
        check("lvl_prio_out", bus.o_out, 8'hA5);
        check("lvl_prio_rise", bus.o_rise, 8'h01);
        check("lvl_prio_fall", bus.o_fall, 8'h00);
        cyc();
        check("lvl_rise_drop", bus.o_rise, 8'h00);
        req(8'h00, 8'h00, 8'h01); cyc(); req(8'h00, 8'h00, 8'h00);
        check("lvl_tog_out", bus.o_out, 8'hA4);
        check("lvl_tog_fall", bus.o_fall, 8'h01);
        check("lvl_busy", bus.o_busy, 8'h00);
        cyc();
        check("lvl_fall_drop", bus.o_fall, 8'h00);

        // ONESHOT ch1, hold 4.
        bus.i_mode = 16'h0004;
        cyc();
        check("os_switch_out", bus.o_out, 8'hA4);
        bus.i_hold = 16'd4;
        req(8'h02, 8'h00, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("os_set_out", bus.o_out[1], 1'b1);
        check("os_set_rise", bus.o_rise, 8'h02);
        check("os_set_busy", bus.o_busy, 8'h02);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("os_hold_out", bus.o_out[1], 1'b1);
            check("os_hold_busy", bus.o_busy[1], 1'b1);
        end
        cyc();
        check("os_end_out", bus.o_out[1], 1'b0);
        check("os_end_fall", bus.o_fall, 8'h02);
        check("os_end_busy", bus.o_busy, 8'h00);

        // Retrigger three cycles after the first set: high through t+7.
        cyc();
        req(8'h02, 8'h00, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("os_rt_set", bus.o_out[1], 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("os_rt_pre", bus.o_out[1], 1'b1);
        end
        req(8'h02, 8'h00, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("os_rt_out", bus.o_out[1], 1'b1);
        check("os_rt_rise", bus.o_rise, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("os_rt_hold", bus.o_out[1], 1'b1);
        end
        cyc();
        check("os_rt_end", bus.o_out[1], 1'b0);
        check("os_rt_fall", bus.o_fall, 8'h02);

        // ONESHOT with hold 0 behaves as hold 1.
        bus.i_hold = 16'd0;
        req(8'h02, 8'h00, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("os_h0_out", bus.o_out[1], 1'b1);
        check("os_h0_busy", bus.o_busy, 8'h02);
        cyc();
        check("os_h0_end", bus.o_out[1], 1'b0);
        check("os_h0_fall", bus.o_fall, 8'h02);

        // BLINK ch2, hold 3 (ch2 is already high from reset value).
        bus.i_mode = 16'h0024;
        cyc();
        check("bl_switch_out", bus.o_out, 8'hA4);
        bus.i_hold = 16'd3;
        req(8'h04, 8'h00, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        for (int j = 0; j < 13; j++) begin
            if (j > 0) cyc();
            check($sformatf("bl_out_%0d", j), bus.o_out[2], bl_out[j]);
            check($sformatf("bl_rise_%0d", j), bus.o_rise[2], bl_rise[j]);
            check($sformatf("bl_fall_%0d", j), bus.o_fall[2], bl_fall[j]);
            check($sformatf("bl_busy_%0d", j), bus.o_busy[2], 1'b1);
        end
        req(8'h00, 8'h04, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("bl_stop_out", bus.o_out, 8'hA0);
        check("bl_stop_busy", bus.o_busy, 8'h00);
        check("bl_stop_fall", bus.o_fall, 8'h04);

        // BLINK ch3 hold 2, then switch to LEVEL while high with a clear
        // request in the switch cycle: the request must be ignored.
        bus.i_mode = 16'h00A4;
        cyc();
        bus.i_hold = 16'd2;
        req(8'h08, 8'h00, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("sw_run_out", bus.o_out, 8'hA8);
        check("sw_run_busy", bus.o_busy, 8'h08);
        bus.i_mode = 16'h0024;
        req(8'h00, 8'h08, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("sw_hold_out", bus.o_out, 8'hA8);
        check("sw_hold_busy", bus.o_busy, 8'h00);
        check("sw_hold_fall", bus.o_fall, 8'h00);
        for (int i = 0; i < 3; i++) cyc();
        check("sw_level_out", bus.o_out, 8'hA8);

        // Restart blink on ch2 and reset asynchronously mid-count.
        req(8'h04, 8'h00, 8'h00); cyc(); req(8'h00, 8'h00, 8'h00);
        check("ar_run_busy", bus.o_busy, 8'h04);
        check("ar_run_out", bus.o_out, 8'hAC);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out", bus.o_out, 8'hA5);
        check("ar_flags", {bus.o_rise, bus.o_fall, bus.o_busy}, 24'h0);
        cyc();
        rst_n = 1'b1;
        bus.i_mode = 16'h0000;
        cyc();
        check("ar_release_out", bus.o_out, 8'hA5);
        check("ar_release_flags", {bus.o_rise, bus.o_fall, bus.o_busy}, 24'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
